ibex_sec_erase_seq: RTL and testbench
=====================================

IBEX_SEC_ERASE_SEQ -- requirements
Module: ibex_sec_erase_seq

Interface
REQ-001 SHALL have parameter NumRegs, default 32, register count; power of two, 16..64.
REQ-002 SHALL have parameter DataWidth, default 32, register width in bits.
REQ-003 SHALL have parameter WrPorts, default 1, register-file write ports driven per cycle; legal values 1 or 2.
REQ-004 SHALL have parameter LfsrSeed, default 32'hACE1_2468, non-zero LFSR reset value.
REQ-005 SHALL have localparams Half = NumRegs/2 and AddrW = log2(NumRegs).
REQ-006 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port erase_req_i  input  1  erase request from the ID stage (OPCODE_SEC_ERSL/ERSH decode).
REQ-009 SHALL have port erase_ready_o  output  1  sequencer can accept a request.
REQ-010 SHALL have port erase_bank_i  input  1  0 = low bank (regs 0..Half-1), 1 = high bank (regs Half..NumRegs-1).
REQ-011 SHALL have port erase_mask_i  input  Half  bit i selects register bank*Half+i.
REQ-012 SHALL have port erase_mode_i  input  1  0 = zero fill, 1 = LFSR pseudo-random fill.
REQ-013 SHALL have port flush_i  input  1  pipeline flush/exception; aborts the sweep.
REQ-014 SHALL have port rf_we_o  output  WrPorts  per-port register-file write enable.
REQ-015 SHALL have port rf_waddr_o  output  WrPorts*AddrW  per-port write address, port p in slice p.
REQ-016 SHALL have port rf_wdata_o  output  WrPorts*DataWidth  per-port write data, port p in slice p.
REQ-017 SHALL have port busy_o  output  1  high in SWEEP and DONE; ID stage stalls on it.
REQ-018 SHALL have port done_o  output  1  one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE, SWEEP, DONE; erase_ready_o = (state == IDLE).
REQ-020 SHALL, in IDLE with erase_req_i high, latch mask, bank and mode; requests outside IDLE are ignored.
REQ-021 SHALL force mask bit 0 to 0 when bank = 0 (x0 is never written).
REQ-022 SHALL go IDLE->SWEEP when the latched mask is non-zero, else IDLE->DONE.
REQ-023 SHALL, each SWEEP cycle, select the WrPorts lowest-index set mask bits, assert rf_we_o for each (port 0 = lowest), drive address bank*Half+index, and clear those bits.
REQ-024 SHALL hold rf_we_o low for unused ports, and for all ports outside SWEEP.
REQ-025 SHALL go SWEEP->DONE in the cycle the last set bit is written; N set bits take ceil(N/WrPorts) write cycles.
REQ-026 SHALL assert done_o for exactly the one DONE cycle, then return to IDLE; a new request is accepted the cycle after DONE.
REQ-027 SHALL drive rf_wdata_o to all-zero in mode 0; in mode 1, port p data = LFSR state rotated left by 8*p bits, truncated/replicated to DataWidth.
REQ-028 SHALL use a 32-bit Galois LFSR, tap mask 32'h8020_0003, stepping every clock cycle regardless of state.
REQ-029 SHALL, on flush_i in SWEEP or DONE, suppress rf_we_o and done_o that cycle and return to IDLE next cycle; flush_i in IDLE has no effect.
REQ-030 SHALL give flush_i priority over sweep progress when both apply in the same cycle.

Reset
REQ-031 SHALL, while rst_i is high, set state IDLE, latched mask 0, LFSR = LfsrSeed; rf_we_o = 0, done_o = 0, busy_o = 0, erase_ready_o = 1 at the next edge.
REQ-032 SHALL abort any in-progress sweep on reset mid-operation with no further writes and no done_o pulse.

Verification
REQ-033 SHALL cover: WrPorts=1, bank 0, mask 16'h0007, mode 0 -> writes to x1, x2 on two consecutive cycles, data 0, done_o on the third cycle.
REQ-034 SHALL cover: WrPorts=2, bank 1, mask 16'hF001, mode 0 -> cycle 1 writes x16, x28; cycle 2 writes x29, x30; cycle 3 writes x31 on port 0 only; done_o next cycle.
REQ-035 SHALL cover: bank 0, mask 16'h0001 -> no rf_we_o at all, done_o one cycle after acceptance.
REQ-036 SHALL cover: mode 1, WrPorts=2 -> port 1 data equals port 0 data rotated left by 8, and both match a reference LFSR model started from 32'hACE1_2468.
REQ-037 SHALL cover: flush_i asserted in the second SWEEP cycle of mask 16'h00FE -> only x1 written, no done_o, erase_ready_o high the next cycle.
REQ-038 SHALL cover: rst_i asserted mid-sweep, and erase_req_i held high during SWEEP -> sweep aborted or request ignored respectively, no extra writes.

Source files
------------

// File: rtl/ibex_sec_erase_seq.sv
// ibex_sec_erase_seq: sweeps a masked register bank, writing zero or LFSR data through the RF write ports
module ibex_sec_erase_seq #(
  parameter int          NumRegs   = 32,
  parameter int          DataWidth = 32,
  parameter int          WrPorts   = 1,
  parameter logic [31:0] LfsrSeed  = 32'hACE1_2468
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           erase_req_i,
  output logic                           erase_ready_o,
  input  logic                           erase_bank_i,
  input  logic [NumRegs/2-1:0]           erase_mask_i,
  input  logic                           erase_mode_i,
  input  logic                           flush_i,
  output logic [WrPorts-1:0]             rf_we_o,
  output logic [WrPorts*$clog2(NumRegs)-1:0] rf_waddr_o,
  output logic [WrPorts*DataWidth-1:0]   rf_wdata_o,
  output logic                           busy_o,
  output logic                           done_o
);
  localparam int Half  = NumRegs / 2;
  localparam int AddrW = $clog2(NumRegs);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;
  state_e               state;
  logic [Half-1:0]      mask_q, mask_nxt, req_mask;
  logic                 bank_q, mode_q, act;
  logic [31:0]          lfsr, rot;
  logic [WrPorts-1:0]   sel;
  logic [AddrW-2:0]     idx [WrPorts];
  assign req_mask      = erase_mask_i & ~{{(Half-1){1'b0}}, ~erase_bank_i};
  assign act           = state == SWEEP && !flush_i && !rst_i;
  assign erase_ready_o = state == IDLE;
  assign busy_o        = state != IDLE;
  assign done_o        = state == DONE && !flush_i && !rst_i;
  // pick the WrPorts lowest set mask bits, lowest index on port 0
  always_comb begin
    mask_nxt = mask_q;
    sel = '0;
    for (int p = 0; p < WrPorts; p++) begin
      idx[p] = '0;
      for (int i = Half - 1; i >= 0; i--) if (mask_nxt[i]) idx[p] = (AddrW-1)'(i);
      sel[p] = |mask_nxt;
      mask_nxt[idx[p]] = 1'b0;
    end
  end
  // drive per-port enables, addresses and fill data
  always_comb begin
    rf_we_o = '0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    rot = '0;
    for (int p = 0; p < WrPorts; p++) begin
      rot = 32'({lfsr, lfsr} >> (32 - 8 * (p % 4)));
      rf_we_o[p] = act & sel[p];
      rf_waddr_o[p*AddrW +: AddrW] = {bank_q, idx[p]};
      for (int b = 0; b < DataWidth; b++) rf_wdata_o[p*DataWidth + b] = mode_q & rot[b % 32];
    end
  end
  // free-running Galois LFSR for random fill
  always_ff @(posedge clk_i)
    lfsr <= rst_i ? LfsrSeed : (lfsr[0] ? (lfsr >> 1) ^ 32'h8020_0003 : lfsr >> 1);
  // sequencer FSM: accept, sweep, pulse done; flush aborts back to idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      mask_q <= '0;
      bank_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (erase_req_i) begin
          mask_q <= req_mask;
          bank_q <= erase_bank_i;
          mode_q <= erase_mode_i;
          state  <= |req_mask ? SWEEP : DONE;
        end
        SWEEP: begin
          mask_q <= flush_i ? '0 : mask_nxt;
          state  <= flush_i ? IDLE : (|mask_nxt ? SWEEP : DONE);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ibex_sec_erase_seq.sv
// tb_ibex_sec_erase_seq: table-driven check of one- and two-port erase sequencers
module tb_ibex_sec_erase_seq;
  logic        clk = 0, rst = 1, req = 0, bank = 0, mode = 0, flush = 0;
  logic [15:0] mask = '0;
  logic        rdy1, busy1, done1, rdy2, busy2, done2;
  logic [0:0]  we1;
  logic [4:0]  wa1;
  logic [31:0] wd1;
  logic [1:0]  we2;
  logic [9:0]  wa2;
  logic [63:0] wd2;
  logic [31:0] model_lfsr;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ibex_sec_erase_seq #(.WrPorts(1)) d1 (
    .clk_i(clk), .rst_i(rst), .erase_req_i(req), .erase_ready_o(rdy1), .erase_bank_i(bank),
    .erase_mask_i(mask), .erase_mode_i(mode), .flush_i(flush), .rf_we_o(we1),
    .rf_waddr_o(wa1), .rf_wdata_o(wd1), .busy_o(busy1), .done_o(done1));
  ibex_sec_erase_seq #(.WrPorts(2)) d2 (
    .clk_i(clk), .rst_i(rst), .erase_req_i(req), .erase_ready_o(rdy2), .erase_bank_i(bank),
    .erase_mask_i(mask), .erase_mode_i(mode), .flush_i(flush), .rf_we_o(we2),
    .rf_waddr_o(wa2), .rf_wdata_o(wd2), .busy_o(busy2), .done_o(done2));
  always @(posedge clk)
    model_lfsr <= rst ? 32'hACE1_2468 : (model_lfsr[0] ? (model_lfsr >> 1) ^ 32'h8020_0003 : model_lfsr >> 1);
  typedef struct {
    logic rs, rq, bk, fl;
    logic [15:0] mk;
    logic w1, d1, r1, d2, r2;
    logic [4:0] a1, a20, a21;
    logic [1:0] w2;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(input logic rs, rq, bk, input logic [15:0] mk, input logic fl,
                             input logic w1, input logic [4:0] a1, input logic d1, r1,
                             input logic [1:0] w2, input logic [4:0] a20, a21, input logic d2, r2);
    vec_t t;
    t.rs = rs; t.rq = rq; t.bk = bk; t.mk = mk; t.fl = fl;
    t.w1 = w1; t.a1 = a1; t.d1 = d1; t.r1 = r1;
    t.w2 = w2; t.a20 = a20; t.a21 = a21; t.d2 = d2; t.r2 = r2;
    return t;
  endfunction
  task automatic chk(input int row, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d act=%h exp=%h", nm, row, act, exp);
    end
  endtask
  initial begin
    vec_t t;
    logic [9:0] a2m, e2m;
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,1,0,16'h0007,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 1,1,0,0, 3,1,2,0,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 1,2,0,0, 0,0,0,1,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,1,0, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,1,1,16'hF001,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 1,16,0,0, 3,16,28,0,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 1,28,0,0, 3,29,30,0,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 1,29,0,0, 1,31,0,0,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 1,30,0,0, 0,0,0,1,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 1,31,0,0, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,1,0, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,1,0,16'h0001,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,1,0, 0,0,0,1,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,1,0,16'h00FE,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 1,1,0,0, 3,1,2,0,0));
    tbl.push_back(v(0,0,0,16'h0000,1, 0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,1,0,16'h0006,1, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 1,1,0,0, 3,1,2,0,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 1,2,0,0, 0,0,0,1,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,1,0, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,1,0,16'h000C,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,1,1,16'hFFFF,0, 1,2,0,0, 3,2,3,0,0));
    tbl.push_back(v(0,1,1,16'hFFFF,0, 1,3,0,0, 0,0,0,1,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,1,0, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,1,0,16'h00FE,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 1,1,0,0, 3,1,2,0,0));
    tbl.push_back(v(1,0,0,16'h0000,0, 0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,16'h0000,0, 0,0,0,1, 0,0,0,0,1));
    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      @(posedge clk);
      #1;
      rst = t.rs; req = t.rq; bank = t.bk; mask = t.mk; flush = t.fl; mode = 0;
      @(negedge clk);
      chk(i, "we1", 64'(we1), 64'(t.w1));
      if (t.w1) chk(i, "addr1", 64'(wa1), 64'(t.a1));
      chk(i, "done1", 64'(done1), 64'(t.d1));
      chk(i, "ready1", 64'(rdy1), 64'(t.r1));
      chk(i, "busy1", 64'(busy1), 64'(!t.r1));
      chk(i, "we2", 64'(we2), 64'(t.w2));
      a2m = {we2[1] ? wa2[9:5] : 5'd0, we2[0] ? wa2[4:0] : 5'd0};
      e2m = {t.w2[1] ? t.a21 : 5'd0, t.w2[0] ? t.a20 : 5'd0};
      chk(i, "addr2", 64'(a2m), 64'(e2m));
      chk(i, "done2", 64'(done2), 64'(t.d2));
      chk(i, "ready2", 64'(rdy2), 64'(t.r2));
      chk(i, "busy2", 64'(busy2), 64'(!t.r2));
      chk(i, "wdata_zero", {wd1 | wd2[31:0], wd2[63:32]}, 64'd0);
    end
    @(posedge clk);
    #1;
    flush = 0; rst = 0; req = 1; bank = 0; mask = 16'h0006; mode = 1;
    @(posedge clk);
    #1;
    req = 0; mode = 0; mask = '0;
    @(negedge clk);
    chk(100, "lfsr_we1", 64'(we1), 64'd1);
    chk(100, "lfsr_d1", 64'(wd1), 64'(model_lfsr));
    chk(100, "lfsr_we2", 64'(we2), 64'd3);
    chk(100, "lfsr_d2p0", 64'(wd2[31:0]), 64'(model_lfsr));
    chk(100, "lfsr_d2p1", 64'(wd2[63:32]), 64'({model_lfsr[23:0], model_lfsr[31:24]}));
    chk(100, "lfsr_rot", 64'(wd2[63:32]), 64'({wd2[23:0], wd2[31:24]}));
    @(negedge clk);
    chk(101, "lfsr_we1b", 64'(we1), 64'd1);
    chk(101, "lfsr_d1b", 64'(wd1), 64'(model_lfsr));
    chk(101, "done2_m1", 64'(done2), 64'd1);
    repeat (3) @(negedge clk);
    chk(102, "ready_end", {rdy1, rdy2}, 64'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
